// File: rtl/decode_sched.sv
// -----------------------------------------------------------------------------
// decode_sched
//   Decode/schedule stage between fetch and execute. Instructions are
//   pre-decoded (immediate type and legality) as they are accepted, so every
//   output is driven straight from a register. A two-entry buffer (output
//   register OUT plus a skid register SKID) lets inst_ready_o depend only on
//   local state and flush, never on dec_ready_i, while still sustaining one
//   entry per cycle.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   flush_i               drop all held entries (redirect)
//   inst_valid_i/ready_o  fetch handshake, inst_i / pc_i payload
//   dec_valid_o/ready_i   execute handshake
//   inst_o, pc_o          registered instruction word and PC
//   imm_sel_o[5:1]        one-hot immediate select: 1=I 2=S 3=B 4=U 5=J
//   illegal_o             unrecognised opcode
//   stall_cnt_o           saturating count of cycles with valid && !ready
// -----------------------------------------------------------------------------
module decode_sched #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  pc_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [5:1]       imm_sel_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Returns {illegal, imm_sel[5:1]}; imm_sel is zero or exactly one-hot.
    function automatic logic [5:0] decode_op(input logic [6:0] op);
        logic [5:0] res;
        res = 6'b1_00000;
        if (op[1:0] == 2'b11) begin
            case (op)
                7'b0000011, 7'b0010011, 7'b0011011,
                7'b1100111, 7'b1110011, 7'b0001111: res = 6'b0_00001;
                7'b0100011:                         res = 6'b0_00010;
                7'b1100011:                         res = 6'b0_00100;
                7'b0110111, 7'b0010111:             res = 6'b0_01000;
                7'b1101111:                         res = 6'b0_10000;
                7'b0110011, 7'b0111011:             res = 6'b0_00000;
                default:                            res = 6'b1_00000;
            endcase
        end
        return res;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    // ---- stage p0: combinational pre-decode of the offered instruction ----
    logic [5:0] dec_p0;
    logic       in_xfer_p0;
    logic       out_xfer_p0;

    // ---- stage p1: OUT and SKID entries ----
    logic             out_vld_p1;
    logic [31:0]      out_inst_p1;
    logic [XLEN-1:0]  out_pc_p1;
    logic [5:1]       out_imm_p1;
    logic             out_ill_p1;

    logic             skid_vld_p1;
    logic [31:0]      skid_inst_p1;
    logic [XLEN-1:0]  skid_pc_p1;
    logic [5:1]       skid_imm_p1;
    logic             skid_ill_p1;

    logic [CNT_W-1:0] stall_cnt_p1;

    assign dec_p0       = decode_op(inst_i[6:0]);
    assign inst_ready_o = !skid_vld_p1 && !flush_i;
    assign in_xfer_p0   = inst_valid_i && inst_ready_o;
    assign out_xfer_p0  = out_vld_p1 && dec_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld_p1   <= 1'b0;
            out_inst_p1  <= '0;
            out_pc_p1    <= '0;
            out_imm_p1   <= '0;
            out_ill_p1   <= 1'b0;
            skid_vld_p1  <= 1'b0;
            stall_cnt_p1 <= '0;
        end else begin
            // Counting is independent of flush: a stalled cycle is a stall.
            if (out_vld_p1 && !dec_ready_i)
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);

            if (flush_i) begin
                out_vld_p1  <= 1'b0;
                skid_vld_p1 <= 1'b0;
            end else if (!out_vld_p1 || out_xfer_p0) begin
                // OUT frees up: the older SKID entry always goes first.
                if (skid_vld_p1) begin
                    out_vld_p1  <= 1'b1;
                    out_inst_p1 <= skid_inst_p1;
                    out_pc_p1   <= skid_pc_p1;
                    out_imm_p1  <= skid_imm_p1;
                    out_ill_p1  <= skid_ill_p1;
                    skid_vld_p1 <= 1'b0;
                end else if (in_xfer_p0) begin
                    out_vld_p1  <= 1'b1;
                    out_inst_p1 <= inst_i;
                    out_pc_p1   <= pc_i;
                    out_imm_p1  <= dec_p0[4:0];
                    out_ill_p1  <= dec_p0[5];
                end else begin
                    out_vld_p1  <= 1'b0;
                end
            end else if (in_xfer_p0) begin
                skid_vld_p1 <= 1'b1;
            end
        end
    end

    // SKID payload needs no reset: it is only ever read while skid_vld_p1=1.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && out_vld_p1 && !out_xfer_p0 && in_xfer_p0) begin
            skid_inst_p1 <= inst_i;
            skid_pc_p1   <= pc_i;
            skid_imm_p1  <= dec_p0[4:0];
            skid_ill_p1  <= dec_p0[5];
        end
    end

    assign dec_valid_o = out_vld_p1;
    assign inst_o      = out_inst_p1;
    assign pc_o        = out_pc_p1;
    assign imm_sel_o   = out_imm_p1;
    assign illegal_o   = out_ill_p1;
    assign stall_cnt_o = stall_cnt_p1;

endmodule

// File: tb/tb_decode_sched.sv
module tb_decode_sched;

    localparam int XLEN  = 64;
    localparam int CNT_W = 32;

    localparam logic [5:1] IMM_NONE = 5'b00000;
    localparam logic [5:1] IMM_I    = 5'b00001;
    localparam logic [5:1] IMM_S    = 5'b00010;
    localparam logic [5:1] IMM_B    = 5'b00100;
    localparam logic [5:1] IMM_U    = 5'b01000;
    localparam logic [5:1] IMM_J    = 5'b10000;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             inst_valid_i;
    logic             inst_ready_o;
    logic [31:0]      inst_i;
    logic [XLEN-1:0]  pc_i;
    logic             dec_valid_o;
    logic             dec_ready_i;
    logic [31:0]      inst_o;
    logic [XLEN-1:0]  pc_o;
    logic [5:1]       imm_sel_o;
    logic             illegal_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Narrow-counter instance sharing all inputs, to reach saturation quickly.
    logic             s_inst_ready_o;
    logic             s_dec_valid_o;
    logic [31:0]      s_inst_o;
    logic [XLEN-1:0]  s_pc_o;
    logic [5:1]       s_imm_sel_o;
    logic             s_illegal_o;
    logic [3:0]       s_stall_cnt_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    decode_sched #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .inst_o(inst_o), .pc_o(pc_o), .imm_sel_o(imm_sel_o),
        .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
    );

    decode_sched #(.XLEN(XLEN), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(s_inst_ready_o),
        .inst_i(inst_i), .pc_i(pc_i),
        .dec_valid_o(s_dec_valid_o), .dec_ready_i(dec_ready_i),
        .inst_o(s_inst_o), .pc_o(s_pc_o), .imm_sel_o(s_imm_sel_o),
        .illegal_o(s_illegal_o), .stall_cnt_o(s_stall_cnt_o)
    );

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0;
        inst_i = '0; pc_i = '0; dec_ready_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
    endtask

    task automatic offer(input logic [31:0] w, input logic [XLEN-1:0] p);
        inst_valid_i = 1'b1; inst_i = w; pc_i = p;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++; if (dec_valid_o !== 1'b0) $display("FAIL rst_dec_valid got %0b want 0", dec_valid_o); else pass_cnt++;
        total_cnt++; if (inst_ready_o !== 1'b1) $display("FAIL rst_inst_ready got %0b want 1", inst_ready_o); else pass_cnt++;
        total_cnt++; if (imm_sel_o !== IMM_NONE) $display("FAIL rst_imm_sel got %b want 00000", imm_sel_o); else pass_cnt++;
        total_cnt++; if (illegal_o !== 1'b0) $display("FAIL rst_illegal got %0b want 0", illegal_o); else pass_cnt++;
        total_cnt++; if (stall_cnt_o !== '0) $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt_o); else pass_cnt++;
        total_cnt++; if (inst_o !== 32'h0 || pc_o !== '0) $display("FAIL rst_inst_pc got %h/%h want 0/0", inst_o, pc_o); else pass_cnt++;
    endtask

    task automatic test_lui();
        do_reset();
        dec_ready_i = 1'b1;
        offer(32'h123452B7, 64'h80000000);
        step();
        inst_valid_i = 1'b0;
        total_cnt++; if (dec_valid_o !== 1'b1) $display("FAIL lui_valid got %0b want 1", dec_valid_o); else pass_cnt++;
        total_cnt++; if (imm_sel_o !== IMM_U) $display("FAIL lui_imm_sel got %b want 01000", imm_sel_o); else pass_cnt++;
        total_cnt++; if (illegal_o !== 1'b0) $display("FAIL lui_illegal got %0b want 0", illegal_o); else pass_cnt++;
        total_cnt++; if (pc_o !== 64'h80000000 || inst_o !== 32'h123452B7) $display("FAIL lui_payload got %h/%h want 80000000/123452b7", pc_o, inst_o); else pass_cnt++;
        step();
        total_cnt++; if (dec_valid_o !== 1'b0) $display("FAIL lui_drain got %0b want 0", dec_valid_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4];
        logic [5:1]  imms  [4];
        words = '{32'h00112023, 32'h00000463, 32'h008000EF, 32'h002081B3};
        imms  = '{IMM_S, IMM_B, IMM_J, IMM_NONE};
        do_reset();
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(words[i], 64'h1000 + 64'(4 * i));
            #1;
            total_cnt++; if (inst_ready_o !== 1'b1) $display("FAIL b2b_ready[%0d] got %0b want 1", i, inst_ready_o); else pass_cnt++;
            step();
            total_cnt++;
            if (dec_valid_o !== 1'b1 || imm_sel_o !== imms[i] || inst_o !== words[i] || illegal_o !== 1'b0)
                $display("FAIL b2b_out[%0d] got v=%0b imm=%b inst=%h ill=%0b want v=1 imm=%b inst=%h ill=0",
                         i, dec_valid_o, imm_sel_o, inst_o, illegal_o, imms[i], words[i]);
            else pass_cnt++;
        end
        inst_valid_i = 1'b0;
        step();
        total_cnt++; if (dec_valid_o !== 1'b0) $display("FAIL b2b_drain got %0b want 0", dec_valid_o); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        offer(32'h123452B7, 64'h100);                       // A: LUI
        step();
        total_cnt++; if (dec_valid_o !== 1'b1 || inst_o !== 32'h123452B7 || stall_cnt_o !== 0) $display("FAIL bp_a got v=%0b inst=%h cnt=%0d want 1/123452b7/0", dec_valid_o, inst_o, stall_cnt_o); else pass_cnt++;
        offer(32'h00112023, 64'h104);                       // B: SW
        #1;
        total_cnt++; if (inst_ready_o !== 1'b1) $display("FAIL bp_ready_b got %0b want 1", inst_ready_o); else pass_cnt++;
        step();
        total_cnt++; if (inst_o !== 32'h123452B7 || stall_cnt_o !== 1) $display("FAIL bp_hold1 got inst=%h cnt=%0d want 123452b7/1", inst_o, stall_cnt_o); else pass_cnt++;
        offer(32'h00000013, 64'h108);                       // C: ADDI
        #1;
        total_cnt++; if (inst_ready_o !== 1'b0) $display("FAIL bp_ready_c got %0b want 0", inst_ready_o); else pass_cnt++;
        for (int k = 2; k <= 3; k++) begin
            step();
            total_cnt++;
            if (inst_o !== 32'h123452B7 || pc_o !== 64'h100 || imm_sel_o !== IMM_U || illegal_o !== 1'b0 || stall_cnt_o !== CNT_W'(k) || inst_ready_o !== 1'b0)
                $display("FAIL bp_stable[%0d] got inst=%h pc=%h imm=%b cnt=%0d rdy=%0b want 123452b7/100/01000/%0d/0",
                         k, inst_o, pc_o, imm_sel_o, stall_cnt_o, inst_ready_o, k);
            else pass_cnt++;
        end
        dec_ready_i = 1'b1;
        step();
        total_cnt++; if (inst_o !== 32'h00112023 || pc_o !== 64'h104 || imm_sel_o !== IMM_S || stall_cnt_o !== 3) $display("FAIL bp_rel_b got inst=%h pc=%h imm=%b cnt=%0d want 00112023/104/00010/3", inst_o, pc_o, imm_sel_o, stall_cnt_o); else pass_cnt++;
        step();
        inst_valid_i = 1'b0;
        total_cnt++; if (dec_valid_o !== 1'b1 || inst_o !== 32'h00000013 || pc_o !== 64'h108 || imm_sel_o !== IMM_I) $display("FAIL bp_rel_c got v=%0b inst=%h pc=%h imm=%b want 1/00000013/108/00001", dec_valid_o, inst_o, pc_o, imm_sel_o); else pass_cnt++;
        step();
        total_cnt++; if (dec_valid_o !== 1'b0) $display("FAIL bp_drain got %0b want 0", dec_valid_o); else pass_cnt++;
    endtask

    task automatic test_flush();
        int stale;
        do_reset();
        offer(32'h123452B7, 64'h200); step();
        offer(32'h00112023, 64'h204); step();
        offer(32'h00000463, 64'h208);
        flush_i = 1'b1;
        #1;
        total_cnt++; if (inst_ready_o !== 1'b0) $display("FAIL fl_ready_during got %0b want 0", inst_ready_o); else pass_cnt++;
        step();
        flush_i = 1'b0; inst_valid_i = 1'b0;
        #1;
        total_cnt++; if (dec_valid_o !== 1'b0 || inst_ready_o !== 1'b1) $display("FAIL fl_after got v=%0b rdy=%0b want 0/1", dec_valid_o, inst_ready_o); else pass_cnt++;
        total_cnt++; if (stall_cnt_o !== 2) $display("FAIL fl_stall_kept got %0d want 2", stall_cnt_o); else pass_cnt++;
        dec_ready_i = 1'b1;
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (dec_valid_o !== 1'b0) stale++;
        end
        total_cnt++; if (stale != 0) $display("FAIL fl_no_stale got %0d valid cycles want 0", stale); else pass_cnt++;
        offer(32'h008000EF, 64'h300);
        step();
        inst_valid_i = 1'b0;
        total_cnt++; if (dec_valid_o !== 1'b1 || inst_o !== 32'h008000EF || imm_sel_o !== IMM_J) $display("FAIL fl_next got v=%0b inst=%h imm=%b want 1/008000ef/10000", dec_valid_o, inst_o, imm_sel_o); else pass_cnt++;
        step();
    endtask

    task automatic test_illegal();
        logic [31:0] words [4];
        logic        ills  [4];
        logic [5:1]  imms  [4];
        words = '{32'h0000007F, 32'h00000010, 32'h00000033, 32'h0000000F};
        ills  = '{1'b1, 1'b1, 1'b0, 1'b0};
        imms  = '{IMM_NONE, IMM_NONE, IMM_NONE, IMM_I};
        do_reset();
        dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(words[i], 64'h400 + 64'(4 * i));
            step();
            total_cnt++;
            if (dec_valid_o !== 1'b1 || illegal_o !== ills[i] || imm_sel_o !== imms[i])
                $display("FAIL ill[%0d] inst=%h got v=%0b ill=%0b imm=%b want 1/%0b/%b", i, words[i], dec_valid_o, illegal_o, imm_sel_o, ills[i], imms[i]);
            else pass_cnt++;
        end
        inst_valid_i = 1'b0;
        step();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        offer(32'h123452B7, 64'h500); step();
        offer(32'h00112023, 64'h504); step();
        step();                                              // stall_cnt now 2
        offer(32'h00000463, 64'h508);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total_cnt++; if (dec_valid_o !== 1'b0 || stall_cnt_o !== 0) $display("FAIL rm_after got v=%0b cnt=%0d want 0/0", dec_valid_o, stall_cnt_o); else pass_cnt++;
        total_cnt++; if (inst_o !== 32'h0 || pc_o !== '0 || imm_sel_o !== IMM_NONE) $display("FAIL rm_data got inst=%h pc=%h imm=%b want 0/0/00000", inst_o, pc_o, imm_sel_o); else pass_cnt++;
        dec_ready_i = 1'b1;
        offer(32'h002081B3, 64'h600);
        step();
        inst_valid_i = 1'b0;
        total_cnt++; if (dec_valid_o !== 1'b1 || inst_o !== 32'h002081B3 || pc_o !== 64'h600) $display("FAIL rm_first got v=%0b inst=%h pc=%h want 1/002081b3/600", dec_valid_o, inst_o, pc_o); else pass_cnt++;
        step();
        total_cnt++; if (dec_valid_o !== 1'b0) $display("FAIL rm_drain got %0b want 0", dec_valid_o); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        offer(32'h00000013, 64'h700);
        step();
        inst_valid_i = 1'b0;
        for (int k = 0; k < 20; k++) step();
        total_cnt++; if (stall_cnt_o !== 20) $display("FAIL sat_wide got %0d want 20", stall_cnt_o); else pass_cnt++;
        total_cnt++; if (s_stall_cnt_o !== 4'hF) $display("FAIL sat_narrow got %0d want 15", s_stall_cnt_o); else pass_cnt++;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; inst_valid_i = 1'b0;
        inst_i = '0; pc_i = '0; dec_ready_i = 1'b0;
        test_reset();
        test_lui();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_midstream();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/decode_sched.md
DECODE_SCHED -- requirements
Module: decode_sched

Interface
Parameters, one per line: name, default, meaning.
REQ-001 SHALL have parameter XLEN, default 64, width of the PC path.
REQ-002 SHALL have parameter CNT_W, default 32, width of the stall performance counter.

Ports, one per line: name, direction, width, meaning.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port flush_i, input, 1, discard all held instructions (redirect).
REQ-006 SHALL have port inst_valid_i, input, 1, fetch offers an instruction.
REQ-007 SHALL have port inst_ready_o, output, 1, this block accepts the offered instruction.
REQ-008 SHALL have port inst_i, input, 32, instruction word.
REQ-009 SHALL have port pc_i, input, XLEN, PC of inst_i.
REQ-010 SHALL have port dec_valid_o, output, 1, decoded entry available to execute.
REQ-011 SHALL have port dec_ready_i, input, 1, execute consumes the entry.
REQ-012 SHALL have port inst_o, output, 32, registered instruction word.
REQ-013 SHALL have port pc_o, output, XLEN, registered PC.
REQ-014 SHALL have port imm_sel_o, output, 5, one-hot immediate select for the immediate generator; bit1=I, bit2=S, bit3=B, bit4=U, bit5=J, indexed [5:1].
REQ-015 SHALL have port illegal_o, output, 1, entry has an unrecognised opcode.
REQ-016 SHALL have port stall_cnt_o, output, CNT_W, count of back-pressure cycles.

Function
REQ-017 SHALL hold two entries: an output register (OUT) and a skid register (SKID), each {valid, inst, pc, imm_sel, illegal}.
REQ-018 SHALL decode imm_sel and illegal from inst_i[6:0] at acceptance, so that outputs are register-driven with zero combinational path from inst_i.
REQ-019 SHALL decode the I type for opcodes 0000011, 0010011, 0011011, 1100111, 1110011 and 0001111.
REQ-020 SHALL decode the S type for opcode 0100011, the B type for 1100011, the U type for 0110111 and 0010111, and the J type for 1101111.
REQ-021 SHALL decode opcodes 0110011 and 0111011 as imm_sel=00000 with illegal=0.
REQ-022 SHALL decode any other opcode, or inst_i[1:0]!=11, as imm_sel=00000 with illegal=1.
REQ-023 SHALL keep imm_sel_o either zero or exactly one-hot at all times.
REQ-024 SHALL drive inst_ready_o = !SKID.valid && !flush_i, a function of state plus flush only, with no dependence on dec_ready_i.
REQ-025 SHALL perform an input transfer when inst_valid_i && inst_ready_o.
REQ-026 SHALL perform an output transfer when dec_valid_o && dec_ready_i.
REQ-027 SHALL drive dec_valid_o = OUT.valid.
REQ-028 SHALL, when OUT is empty or an output transfer occurs: load OUT from SKID if SKID is valid (and clear SKID), else load OUT from the input if an input transfer occurs, else clear OUT.valid.
REQ-029 SHALL, when OUT is full with no output transfer, write an input transfer into SKID.
REQ-030 SHALL, when a simultaneous input and output transfer occurs with SKID valid, move SKID to OUT; in that case the input is not accepted, since inst_ready_o=0.
REQ-031 SHALL preserve order: entries leave in acceptance order, with no loss and no duplication.
REQ-032 SHALL have a latency of 1 cycle from input transfer to dec_valid_o when OUT is empty.
REQ-033 SHALL sustain a throughput of 1 entry per cycle when dec_ready_i=1.
REQ-034 SHALL hold inst_o, pc_o, imm_sel_o and illegal_o stable while dec_valid_o=1 and dec_ready_i=0.
REQ-035 SHALL, on flush_i=1, clear OUT.valid and SKID.valid at the next edge, with no input accepted that cycle; an output transfer in the flush cycle still counts as consumed.
REQ-036 SHALL increment stall_cnt_o each cycle in which dec_valid_o=1 and dec_ready_i=0.
REQ-037 SHALL saturate stall_cnt_o at all-ones, with no wrap.
REQ-038 SHALL not clear stall_cnt_o on flush.

Reset
REQ-039 SHALL, on rst_i=1 at a clock edge, clear OUT.valid, SKID.valid and stall_cnt_o, giving dec_valid_o=0, inst_ready_o=1 after reset (with flush_i=0), imm_sel_o=0, illegal_o=0 and stall_cnt_o=0.
REQ-040 SHALL reset inst_o and pc_o to 0.
REQ-041 SHALL give rst_i priority over flush_i and all transfers.
REQ-042 SHALL, when rst_i is asserted mid-stream with both entries full, discard both entries and accept no input in that cycle.

Verification
REQ-043 SHALL cover single LUI: inst_i=0x123452B7, pc=0x80000000, dec_ready_i=1 -> next cycle dec_valid_o=1, imm_sel_o=01000 (U), illegal_o=0, pc_o=0x80000000.
REQ-044 SHALL cover back-to-back SW 0x00112023, BEQ 0x00000463, JAL 0x008000EF, ADD 0x002081B3 at full rate -> imm_sel_o sequence S, B, J, 00000 on consecutive cycles, with inst_ready_o held at 1.
REQ-045 SHALL cover back-pressure: dec_ready_i=0 while feeding 3 instructions -> first two held in OUT and SKID, inst_ready_o=0 on the third, outputs stable, stall_cnt_o increments every cycle; then release -> entries emerge in order.
REQ-046 SHALL cover flush with both entries full -> next cycle dec_valid_o=0, inst_ready_o=1, and no stale entry is ever emitted.
REQ-047 SHALL cover illegal input: inst_i=0x0000007F, and inst_i=0x00000013 with bits[1:0] forced to 00 -> illegal_o=1, imm_sel_o=00000.
REQ-048 SHALL cover reset mid-stream: rst_i for one cycle while holding 2 entries -> dec_valid_o=0, stall_cnt_o=0, and the first post-reset accepted instruction is emitted normally.
